// File: rtl/z_core_exec_unit.sv
// Single-issue ALU/branch execute unit with valid/ready handshakes.
// Shifts are bit-serial: one bit per cycle, so latency is shamt+1.
module z_core_exec_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_inst_type,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            branch_taken
);

    localparam int SHW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t          state_q, state_d;
    logic [3:0]      op_q, op_d;
    logic [XLEN-1:0] sh_q, sh_d;
    logic [SHW-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            br_q, br_d;

    logic [XLEN-1:0] imm_res;
    logic            imm_br;
    logic            is_shift;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] sh_next;

    assign shamt    = op_b[SHW-1:0];
    assign is_shift = (alu_inst_type == 4'd2) || (alu_inst_type == 4'd6) ||
                      (alu_inst_type == 4'd7);

    // Single-cycle results; a zero-distance shift passes op_a straight through.
    always_comb begin
        imm_res = '0;
        imm_br  = 1'b0;
        case (alu_inst_type)
            4'd0:    imm_res = op_a + op_b;
            4'd1:    imm_res = op_a - op_b;
            4'd2,
            4'd6,
            4'd7:    imm_res = op_a;
            4'd3:    imm_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            4'd4:    imm_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            4'd5:    imm_res = op_a ^ op_b;
            4'd8:    imm_res = op_a | op_b;
            4'd9:    imm_res = op_a & op_b;
            4'd10:   imm_br  = (op_a == op_b);
            4'd11:   imm_br  = (op_a != op_b);
            4'd12:   imm_br  = ($signed(op_a) < $signed(op_b));
            4'd13:   imm_br  = ($signed(op_a) >= $signed(op_b));
            4'd14:   imm_br  = (op_a < op_b);
            default: imm_br  = (op_a >= op_b);
        endcase
        if (alu_inst_type >= 4'd10) begin
            imm_res = {{(XLEN-1){1'b0}}, imm_br};
        end
    end

    always_comb begin
        case (op_q)
            4'd2:    sh_next = {sh_q[XLEN-2:0], 1'b0};
            4'd6:    sh_next = {1'b0, sh_q[XLEN-1:1]};
            default: sh_next = {sh_q[XLEN-1], sh_q[XLEN-1:1]};
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        sh_d     = sh_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        br_d     = br_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d = alu_inst_type;
                    if (is_shift && (shamt != '0)) begin
                        sh_d    = op_a;
                        cnt_d   = shamt;
                        state_d = SHIFT;
                    end else begin
                        result_d = imm_res;
                        br_d     = imm_br;
                        state_d  = DONE;
                    end
                end
            end
            SHIFT: begin
                sh_d  = sh_next;
                cnt_d = cnt_q - SHW'(1);
                if (cnt_q == SHW'(1)) begin
                    result_d = sh_next;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    result_d = '0;
                    br_d     = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= '0;
            sh_q     <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            br_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            sh_q     <= sh_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            br_q     <= br_d;
        end
    end

    assign in_ready     = (state_q == IDLE);
    assign out_valid    = (state_q == DONE);
    assign result       = result_q;
    assign branch_taken = br_q;

endmodule

// File: tb/tb_z_core_exec_unit.sv
// Self-checking bench for z_core_exec_unit (XLEN=32): directed vector table,
// backpressure and reset corner cases, then random ops against a reference model.
module tb_z_core_exec_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_inst_type;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        branch_taken;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    z_core_exec_unit #(.XLEN(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .alu_inst_type(alu_inst_type),
        .op_a         (op_a),
        .op_b         (op_b),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .result       (result),
        .branch_taken (branch_taken)
    );

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        br;
        int          lat;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain arithmetic on the ISA-level meaning of each code.
    function automatic void model(input logic [3:0] op, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] r,
                                  output logic br, output int lat);
        int                 sh;
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sh  = int'(b % 32);
        sa  = a;
        sb  = b;
        r   = 32'h0;
        br  = 1'b0;
        lat = 1;
        case (op)
            4'd0:  r = a + b;
            4'd1:  r = a - b;
            4'd2:  r = a << sh;
            4'd3:  r = (sa < sb) ? 32'd1 : 32'd0;
            4'd4:  r = (a < b) ? 32'd1 : 32'd0;
            4'd5:  r = a ^ b;
            4'd6:  r = a >> sh;
            4'd7:  r = sa >>> sh;
            4'd8:  r = a | b;
            4'd9:  r = a & b;
            4'd10: br = (a == b);
            4'd11: br = (a != b);
            4'd12: br = (sa < sb);
            4'd13: br = !(sa < sb);
            4'd14: br = (a < b);
            4'd15: br = !(a < b);
            default: ;
        endcase
        if (op >= 4'd10) r = br ? 32'd1 : 32'd0;
        if ((op == 4'd2 || op == 4'd6 || op == 4'd7) && sh != 0) lat = sh + 1;
    endfunction

    // Issue one op, measure latency, optionally stall the consumer while
    // holding in_valid high, then confirm the return to IDLE.
    task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] res, input logic br,
                          input int lat, input int stall);
        int   n;
        int   waited;
        logic bad;
        waited = 0;
        while (!in_ready && waited < 100) begin
            step();
            waited++;
        end
        chk({name, " in_ready"}, in_ready, 1);
        out_ready     = (stall == 0);
        in_valid      = 1'b1;
        alu_inst_type = op;
        op_a          = a;
        op_b          = b;
        step();
        in_valid      = 1'b0;
        op_a          = $urandom;
        op_b          = $urandom;
        alu_inst_type = 4'($urandom);
        n   = 1;
        bad = 1'b0;
        while (!out_valid && n < 100) begin
            if (in_ready !== 1'b0 || result !== 32'h0 || branch_taken !== 1'b0) bad = 1'b1;
            step();
            n++;
        end
        chk({name, " busy_outputs"}, bad, 0);
        chk({name, " latency"}, n, lat);
        chk({name, " result"}, result, res);
        chk({name, " branch"}, branch_taken, br);
        if (stall > 0) begin
            bad = 1'b0;
            for (int i = 0; i < stall; i++) begin
                in_valid = 1'b1;
                step();
                if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== res ||
                    branch_taken !== br) bad = 1'b1;
            end
            chk({name, " stall_hold"}, bad, 0);
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        step();
        chk({name, " back_idle"}, {in_ready, out_valid, result, branch_taken},
            {1'b1, 1'b0, 32'h0, 1'b0});
    endtask

    vec_t vecs[14];

    initial begin
        logic [3:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] rres;
        logic        rbr;
        int          rlat;
        int          rstall;
        logic        seen;

        vecs[0]  = '{"add_wrap",   4'd0,  32'hFFFFFFFF, 32'h1,        32'h0,        1'b0, 1};
        vecs[1]  = '{"sra_4",      4'd7,  32'h80000000, 32'h24,       32'hF8000000, 1'b0, 5};
        vecs[2]  = '{"bge_neg",    4'd13, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b0, 1};
        vecs[3]  = '{"bltu_big",   4'd14, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b0, 1};
        vecs[4]  = '{"bgeu_eq",    4'd15, 32'h5,        32'h5,        32'h1,        1'b1, 1};
        vecs[5]  = '{"sll_0",      4'd2,  32'h12345678, 32'h20,       32'h12345678, 1'b0, 1};
        vecs[6]  = '{"sub",        4'd1,  32'h5,        32'h7,        32'hFFFFFFFE, 1'b0, 1};
        vecs[7]  = '{"srl_31",     4'd6,  32'h80000000, 32'h1F,       32'h1,        1'b0, 32};
        vecs[8]  = '{"sll_31",     4'd2,  32'h1,        32'hFFFFFFFF, 32'h80000000, 1'b0, 32};
        vecs[9]  = '{"bne",        4'd11, 32'h3,        32'h4,        32'h1,        1'b1, 1};
        vecs[10] = '{"blt_neg",    4'd12, 32'hFFFFFFFF, 32'h1,        32'h1,        1'b1, 1};
        vecs[11] = '{"sltu",       4'd4,  32'h1,        32'hFFFFFFFF, 32'h1,        1'b0, 1};
        vecs[12] = '{"xor",        4'd5,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1};
        vecs[13] = '{"beq",        4'd10, 32'h7,        32'h7,        32'h1,        1'b1, 1};

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        alu_inst_type = 4'd0;
        op_a = 32'h0;
        op_b = 32'h0;
        step();
        step();
        rst = 1'b0;
        chk("reset_state", {in_ready, out_valid, result, branch_taken},
            {1'b1, 1'b0, 32'h0, 1'b0});

        foreach (vecs[i])
            run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res,
                   vecs[i].br, vecs[i].lat, 0);

        // SLT -3 < 2 held under 10 cycles of backpressure with in_valid asserted.
        run_op("bp_slt", 4'd3, 32'hFFFFFFFD, 32'h2, 32'h1, 1'b0, 1, 10);

        // Reset in the middle of a long shift discards the operation.
        out_ready     = 1'b1;
        in_valid      = 1'b1;
        alu_inst_type = 4'd2;
        op_a          = 32'h1;
        op_b          = 32'd31;
        step();
        in_valid = 1'b0;
        step();
        step();
        step();
        chk("mid_shift_busy", {in_ready, out_valid}, {1'b0, 1'b0});
        rst      = 1'b1;
        in_valid = 1'b1;
        step();
        chk("mid_shift_reset", {in_ready, out_valid, result, branch_taken},
            {1'b1, 1'b0, 32'h0, 1'b0});
        step();
        in_valid = 1'b0;
        rst      = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid !== 1'b0 || in_ready !== 1'b1) seen = 1'b1;
            step();
        end
        chk("no_ghost_result", seen, 0);

        for (int i = 0; i < 150; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            rstall = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
            model(rop, ra, rb, rres, rbr, rlat);
            run_op($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb, rres, rbr, rlat, rstall);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/z_core_exec_unit.md
Z_CORE_EXEC_UNIT -- requirements
Module: z_core_exec_unit

Interface
REQ-001 The block SHALL have exactly one parameter: XLEN, default 32, datapath width in bits; legal values are 32 and 64.
REQ-002 The block SHALL have these ports, in this order:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  upstream presents an operation.
- in_ready  output  1  block accepts an operation this cycle.
- alu_inst_type  input  4  operation code from the ALU control decoder.
- op_a  input  XLEN  first operand.
- op_b  input  XLEN  second operand or immediate.
- out_valid  output  1  result available.
- out_ready  input  1  downstream consumes the result.
- result  output  XLEN  operation result.
- branch_taken  output  1  branch compare outcome.
REQ-003 The block SHALL use one clock. Reset SHALL be synchronous and active-high.

Function
REQ-004 The block SHALL decode alu_inst_type as follows:
- 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND.
- 10 BEQ, 11 BNE, 12 BLT, 13 BGE, 14 BLTU, 15 BGEU.
- All 16 codes are valid.
REQ-005 The block SHALL have three states: IDLE, SHIFT and DONE.
- in_ready = 1 only in IDLE.
- out_valid = 1 only in DONE.
REQ-006 Acceptance SHALL occur on a rising edge where in_valid && in_ready. The operands and alu_inst_type SHALL be captured at that edge. in_valid is ignored outside IDLE.
REQ-007 Non-shift operations SHALL go IDLE->DONE at the accept edge, so out_valid is high the next cycle (latency 1).
REQ-008 Shift amount SHALL be shamt = op_b[log2(XLEN)-1:0]. Upper op_b bits are ignored.
REQ-009 For a shift with shamt=0, the block SHALL go directly to DONE with result = op_a (latency 1).
REQ-010 For a shift with shamt>0, the block SHALL load the shift register with op_a and a counter with shamt, then enter SHIFT.
- Each SHIFT cycle shifts by exactly one bit and decrements the counter.
- SLL fills with 0, SRL fills with 0, SRA fills with the MSB.
- On the edge where the counter goes 1->0, the block SHALL enter DONE.
- Total latency from accept to out_valid is shamt+1 cycles.
REQ-011 Arithmetic SHALL be modulo 2^XLEN; carries and overflow are discarded.
- SLT/SLTU: result = {XLEN-1 zeros, lt}, signed for SLT, unsigned for SLTU.
REQ-012 Branch codes SHALL set branch_taken to the compare outcome and result = {XLEN-1 zeros, branch_taken}.
- BLT/BGE compare signed; BLTU/BGEU compare unsigned.
- BGE/BGEU are taken on equality.
REQ-013 For all non-branch codes, branch_taken SHALL be 0.
REQ-014 In DONE, result and branch_taken SHALL hold stable until out_valid && out_ready. At that edge the block SHALL return to IDLE. in_ready rises the following cycle, so peak throughput is one operation per 2 cycles.
REQ-015 If out_ready is held low, the block SHALL remain in DONE indefinitely with no change to any output.
REQ-016 result and branch_taken SHALL be 0 in IDLE and SHIFT. They SHALL be registered, not combinational, from inputs.
REQ-017 The maximum shift (shamt = XLEN-1) SHALL complete in XLEN cycles with no counter wrap.

Reset
REQ-018 When rst=1 at a rising edge, the block SHALL set:
- state = IDLE
- in_ready = 1 the next cycle
- out_valid = 0, result = 0, branch_taken = 0
- shift counter = 0
REQ-019 Reset SHALL take priority over acceptance, shifting and the output handshake.
REQ-020 An operation in SHIFT or DONE when reset is asserted SHALL be discarded, with no result emitted.
REQ-021 Inputs SHALL be ignored while rst=1; in_ready may be high, but no accept SHALL occur.

Verification
REQ-022 ADD: op_a=0xFFFFFFFF, op_b=1, out_ready=1 -> one cycle later, out_valid=1, result=0x00000000, branch_taken=0; IDLE the next cycle.
REQ-023 SRA: op_a=0x80000000, op_b=0x00000024 (shamt=4) -> in_ready low for 5 cycles; out_valid after 5 cycles with result=0xF8000000.
REQ-024 BGE/BLTU on op_a=0xFFFFFFFF, op_b=1:
- BGE -> branch_taken=0, result=0.
- BLTU -> branch_taken=0.
- BGEU with equal operands 5,5 -> branch_taken=1, result=1.
REQ-025 Backpressure: complete SLT op_a=-3, op_b=2 with out_ready=0 for 10 cycles -> result=1 held stable and in_ready=0 throughout; out_ready=1 -> return to IDLE; in_valid held high during the stall accepts nothing.
REQ-026 Reset mid-shift: SLL with shamt=31, assert rst after 3 SHIFT cycles -> next cycle IDLE with all outputs 0; no out_valid pulse is ever produced for that operation.
REQ-027 SLL with shamt=0, op_a=0x12345678 -> latency 1, result=0x12345678.
